// File: rtl/rggen_bit_field_counter_if.sv
// rggen_bit_field_if: one bit-field slice of a generated register.
//
// Signals (WIDTH bits unless noted):
//   valid      1  register access strobe from the register block
//   read_mask     bits of this slice selected for reading
//   write_mask    bits of this slice selected for writing
//   write_data    software write data
//   read_data     data returned to software
//   value         current field value exported to the register block
//
// Modports:
//   master / slave  register-block side / bit-field side
//   bit_field       alias of slave, used by bit-field implementations
interface rggen_bit_field_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] read_mask;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport master (
        output valid, read_mask, write_mask, write_data,
        input  read_data, value
    );

    modport slave (
        input  valid, read_mask, write_mask, write_data,
        output read_data, value
    );

    modport bit_field (
        input  valid, read_mask, write_mask, write_data,
        output read_data, value
    );
endinterface

// File: rtl/rggen_bit_field_counter.sv
// rggen_bit_field_counter: software-accessible up/down counter bit field.
//
// The counter is written and cleared by software through the bit-field slice
// and counts hardware events. Counting either wraps modulo 2^WIDTH or
// saturates; overflow/underflow are reported as registered one-cycle pulses.
//
// Ports:
//   i_clk         clock
//   i_rst         asynchronous active-high reset
//   bit_field_if  register slice (valid, masks, write_data, read_data, value)
//   i_clear       hardware clear request
//   i_up          count-up event (one increment per cycle)
//   i_down        count-down event (one decrement per cycle)
//   o_value       current counter value
//   o_overflow    pulse: an increment wrapped or was blocked by saturation
//   o_underflow   pulse: a decrement wrapped or was blocked by saturation
module rggen_bit_field_counter #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
    parameter bit               WRITE_FIRST   = 1'b1,
    parameter bit               SATURATE      = 1'b0,
    parameter bit               READ_CLEAR    = 1'b0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    rggen_bit_field_if.bit_field         bit_field_if,
    input  logic                         i_clear,
    input  logic                         i_up,
    input  logic                         i_down,
    output logic [WIDTH-1:0]             o_value,
    output logic                         o_overflow,
    output logic                         o_underflow
);
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;

    logic             write_access;
    logic             read_access;
    logic             clear_req;
    logic             sel_write;
    logic             sel_clear;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_diff;

    // A read that carries any write bit is a write, so it never read-clears.
    assign write_access = bit_field_if.valid & (|bit_field_if.write_mask);
    assign read_access  = bit_field_if.valid & (|bit_field_if.read_mask)
                        & ~(|bit_field_if.write_mask);
    assign clear_req    = i_clear | (READ_CLEAR & read_access);

    assign sel_write = write_access & (WRITE_FIRST | ~clear_req);
    assign sel_clear = clear_req & ~sel_write;

    // The extra MSB carries out on increment from all-ones and borrows on
    // decrement from zero.
    assign inc_sum  = {1'b0, value_q} + (WIDTH+1)'(1);
    assign dec_diff = {1'b0, value_q} - (WIDTH+1)'(1);

    always_comb begin
        value_d     = value_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (sel_write) begin
            value_d = (bit_field_if.write_data & bit_field_if.write_mask)
                    | (value_q & ~bit_field_if.write_mask);
        end else if (sel_clear) begin
            value_d = INITIAL_VALUE;
        end else if (i_up & ~i_down) begin
            if (inc_sum[WIDTH]) begin
                overflow_d = 1'b1;
                value_d    = SATURATE ? value_q : inc_sum[WIDTH-1:0];
            end else begin
                value_d    = inc_sum[WIDTH-1:0];
            end
        end else if (i_down & ~i_up) begin
            if (dec_diff[WIDTH]) begin
                underflow_d = 1'b1;
                value_d     = SATURATE ? value_q : dec_diff[WIDTH-1:0];
            end else begin
                value_d     = dec_diff[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            value_q     <= INITIAL_VALUE;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            value_q     <= value_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Read data is the pre-update register, so a read-clear returns the old
    // value in the access cycle.
    assign bit_field_if.read_data = value_q;
    assign bit_field_if.value     = value_q;
    assign o_value                = value_q;
    assign o_overflow             = overflow_q;
    assign o_underflow            = underflow_q;
endmodule

// File: tb/tb_rggen_bit_field_counter.sv
// Testbench for rggen_bit_field_counter. Five instances share one stimulus:
//   wrap : WIDTH=4 INIT=3 WRITE_FIRST=1 SATURATE=0 READ_CLEAR=0
//   sat  : WIDTH=4 INIT=3 WRITE_FIRST=1 SATURATE=1 READ_CLEAR=0
//   wf0  : WIDTH=4 INIT=3 WRITE_FIRST=0 SATURATE=0 READ_CLEAR=0
//   rc   : WIDTH=4 INIT=3 WRITE_FIRST=1 SATURATE=0 READ_CLEAR=1
//   w1   : WIDTH=1 INIT=0 WRITE_FIRST=1 SATURATE=0 READ_CLEAR=0
module tb_rggen_bit_field_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] rmask = '0;
    logic [3:0] wmask = '0;
    logic [3:0] wdata = '0;
    logic       clr = 1'b0;
    logic       up = 1'b0;
    logic       dn = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rggen_bit_field_if #(.WIDTH(4)) if_wrap ();
    rggen_bit_field_if #(.WIDTH(4)) if_sat ();
    rggen_bit_field_if #(.WIDTH(4)) if_wf0 ();
    rggen_bit_field_if #(.WIDTH(4)) if_rc ();
    rggen_bit_field_if #(.WIDTH(1)) if_w1 ();

    assign if_wrap.valid = valid; assign if_wrap.read_mask = rmask;
    assign if_wrap.write_mask = wmask; assign if_wrap.write_data = wdata;
    assign if_sat.valid = valid; assign if_sat.read_mask = rmask;
    assign if_sat.write_mask = wmask; assign if_sat.write_data = wdata;
    assign if_wf0.valid = valid; assign if_wf0.read_mask = rmask;
    assign if_wf0.write_mask = wmask; assign if_wf0.write_data = wdata;
    assign if_rc.valid = valid; assign if_rc.read_mask = rmask;
    assign if_rc.write_mask = wmask; assign if_rc.write_data = wdata;
    assign if_w1.valid = valid; assign if_w1.read_mask = rmask[0];
    assign if_w1.write_mask = wmask[0]; assign if_w1.write_data = wdata[0];

    logic [3:0] v_wrap, v_sat, v_wf0, v_rc;
    logic [0:0] v_w1;
    logic       ov_wrap, un_wrap, ov_sat, un_sat, ov_wf0, un_wf0;
    logic       ov_rc, un_rc, ov_w1, un_w1;

    rggen_bit_field_counter #(.WIDTH(4), .INITIAL_VALUE(4'h3), .WRITE_FIRST(1'b1),
        .SATURATE(1'b0), .READ_CLEAR(1'b0)) u_wrap (
        .i_clk(clk), .i_rst(rst), .bit_field_if(if_wrap), .i_clear(clr),
        .i_up(up), .i_down(dn), .o_value(v_wrap), .o_overflow(ov_wrap),
        .o_underflow(un_wrap));

    rggen_bit_field_counter #(.WIDTH(4), .INITIAL_VALUE(4'h3), .WRITE_FIRST(1'b1),
        .SATURATE(1'b1), .READ_CLEAR(1'b0)) u_sat (
        .i_clk(clk), .i_rst(rst), .bit_field_if(if_sat), .i_clear(clr),
        .i_up(up), .i_down(dn), .o_value(v_sat), .o_overflow(ov_sat),
        .o_underflow(un_sat));

    rggen_bit_field_counter #(.WIDTH(4), .INITIAL_VALUE(4'h3), .WRITE_FIRST(1'b0),
        .SATURATE(1'b0), .READ_CLEAR(1'b0)) u_wf0 (
        .i_clk(clk), .i_rst(rst), .bit_field_if(if_wf0), .i_clear(clr),
        .i_up(up), .i_down(dn), .o_value(v_wf0), .o_overflow(ov_wf0),
        .o_underflow(un_wf0));

    rggen_bit_field_counter #(.WIDTH(4), .INITIAL_VALUE(4'h3), .WRITE_FIRST(1'b1),
        .SATURATE(1'b0), .READ_CLEAR(1'b1)) u_rc (
        .i_clk(clk), .i_rst(rst), .bit_field_if(if_rc), .i_clear(clr),
        .i_up(up), .i_down(dn), .o_value(v_rc), .o_overflow(ov_rc),
        .o_underflow(un_rc));

    rggen_bit_field_counter #(.WIDTH(1), .INITIAL_VALUE(1'b0), .WRITE_FIRST(1'b1),
        .SATURATE(1'b0), .READ_CLEAR(1'b0)) u_w1 (
        .i_clk(clk), .i_rst(rst), .bit_field_if(if_w1), .i_clear(clr),
        .i_up(up), .i_down(dn), .o_value(v_w1), .o_overflow(ov_w1),
        .o_underflow(un_w1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0; rmask = '0; wmask = '0; wdata = '0;
        clr = 1'b0; up = 1'b0; dn = 1'b0;
    endtask

    task automatic write(input logic [3:0] data, input logic [3:0] mask);
        idle();
        valid = 1'b1; wdata = data; wmask = mask;
        step();
        idle();
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        step(); step();
        check("rst_value", v_wrap, 4'h3);
        check("rst_ovf", ov_wrap, 1'b0);
        check("rst_udf", un_wrap, 1'b0);
        check("rst_w1", v_w1, 1'b0);
        rst = 1'b0;

        // Count, then asynchronous reset in the middle of a cycle
        up = 1'b1;
        step(); step();
        check("cnt_pre_rst", v_wrap, 4'h5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_value", v_wrap, 4'h3);
        check("async_rst_ovf", ov_wrap, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) step();
        check("cnt_5_up", v_wrap, 4'h8);
        check("cnt_5_up_sat", v_sat, 4'h8);
        check("cnt_5_up_w1", v_w1, 1'b1);

        // Wrap / saturate on increment from E
        write(4'hE, 4'hF);
        check("load_E", v_wrap, 4'hE);
        check("load_E_w1", v_w1, 1'b0);
        up = 1'b1;
        step();
        check("wrap_F", v_wrap, 4'hF);
        check("wrap_F_ovf", ov_wrap, 1'b0);
        check("sat_F", v_sat, 4'hF);
        check("w1_toggle1", v_w1, 1'b1);
        step();
        check("wrap_0", v_wrap, 4'h0);
        check("wrap_0_ovf", ov_wrap, 1'b1);
        check("wrap_0_udf", un_wrap, 1'b0);
        check("sat_hold1", v_sat, 4'hF);
        check("sat_ovf1", ov_sat, 1'b1);
        check("w1_wrap", v_w1, 1'b0);
        check("w1_ovf", ov_w1, 1'b1);
        step();
        check("wrap_1", v_wrap, 4'h1);
        check("wrap_1_ovf", ov_wrap, 1'b0);
        check("sat_hold2", v_sat, 4'hF);
        check("sat_ovf2", ov_sat, 1'b1);
        up = 1'b0;

        // Underflow from zero
        write(4'h0, 4'hF);
        dn = 1'b1;
        step();
        check("udf_wrap_F", v_wrap, 4'hF);
        check("udf_wrap_pulse", un_wrap, 1'b1);
        check("udf_wrap_no_ovf", ov_wrap, 1'b0);
        check("udf_sat_0", v_sat, 4'h0);
        check("udf_sat_pulse", un_sat, 1'b1);
        dn = 1'b0;
        step();
        check("udf_pulse_end", un_wrap, 1'b0);
        check("udf_sat_end", un_sat, 1'b0);

        // Write / clear / count collision
        valid = 1'b1; wdata = 4'h5; wmask = 4'hF; clr = 1'b1; up = 1'b1;
        step();
        idle();
        check("prio_wf1", v_wrap, 4'h5);
        check("prio_wf0", v_wf0, 4'h3);
        check("prio_wf1_ovf", ov_wrap, 1'b0);
        check("prio_wf0_ovf", ov_wf0, 1'b0);

        // Partial write, then simultaneous up/down
        write(4'hA, 4'hF);
        write(4'h5, 4'h3);
        check("partial_write", v_wrap, 4'h9);
        up = 1'b1; dn = 1'b1;
        repeat (3) step();
        check("cancel_value", v_wrap, 4'h9);
        check("cancel_ovf", ov_wrap, 1'b0);
        check("cancel_udf", un_wrap, 1'b0);
        idle();

        // Read-clear
        write(4'h7, 4'hF);
        valid = 1'b1; rmask = 4'hF;
        #1;
        check("rc_read_data", if_rc.read_data, 4'h7);
        step();
        check("rc_cleared", v_rc, 4'h3);
        check("rc_no_effect_rc0", v_wrap, 4'h7);
        up = 1'b1;
        step();
        check("rc_with_up", v_rc, 4'h3);
        check("rc_with_up_rc0", v_wrap, 4'h8);
        up = 1'b0; wmask = 4'hF; wdata = 4'h6;
        step();
        idle();
        check("rc_read_write", v_rc, 4'h6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
